// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit controller.
// Size encoding, FSM states, and per-size byte count / byte mask.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC0 = 2'b01,
        ACC1 = 2'b10,
        RESP = 2'b11
    } state_e;

    function automatic logic [2:0] size_bytes(input size_e sz);
        case (sz)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            SZ_WORD: size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input size_e sz);
        case (sz)
            SZ_BYTE: size_mask = 4'b0001;
            SZ_HALF: size_mask = 4'b0011;
            SZ_WORD: size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
        is_misaligned = ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_ext.sv
// Load data extension: sign- or zero-extends the low byte/half of a
// right-justified load value; words pass through unchanged.
module lsu_ext
    import lsu_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    always_comb begin
        case (size_e'(i_size))
            SZ_BYTE: o_data = {{24{~i_unsigned & i_data[7]}}, i_data[7:0]};
            SZ_HALF: o_data = {{16{~i_unsigned & i_data[15]}}, i_data[15:0]};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request at a time, up to two word accesses.
// Define LSU_MISALIGN_EN to split misaligned accesses; otherwise they error.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    output logic              o_mem_wren,
    input  logic [31:0]       i_mem_rdata
);

    state_e            state_q, state_d;
    logic              we_q, we_d, uns_q, uns_d, legal_q, legal_d;
    logic [1:0]        off_q, off_d;
    size_e             size_q, size_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_bmask_q, mem_bmask_d;
    logic              mem_wren_q, mem_wren_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              req_legal, go_split;
    logic [31:0]       ld_lo, ext_in, ext_data;
`ifdef LSU_MISALIGN_EN
    logic [ADDR_W-1:0] hi_addr_q, hi_addr_d;
    logic [31:0]       wdata_q, wdata_d, load_buf_q, load_buf_d;

    assign req_legal = (size_e'(i_req_size) != SZ_ILL);
    assign go_split  = legal_q && (({1'b0, off_q} + size_bytes(size_q)) > 3'd4);
    assign ext_in    = (state_q == ACC1)
                     ? (load_buf_q | (i_mem_rdata << (6'd32 - {1'b0, off_q, 3'b000})))
                     : ld_lo;
`else
    assign req_legal = (size_e'(i_req_size) != SZ_ILL)
                     && !is_misaligned(size_e'(i_req_size), i_req_addr[1:0]);
    assign go_split  = 1'b0;
    assign ext_in    = ld_lo;
`endif

    assign ld_lo = i_mem_rdata >> {off_q, 3'b000};

    lsu_ext u_ext (
        .i_data     (ext_in),
        .i_size     (size_q),
        .i_unsigned (uns_q),
        .o_data     (ext_data)
    );

    // Memory-side outputs are registered, so each access's values are
    // computed on the edge that enters its state.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        uns_d       = uns_q;
        legal_d     = legal_q;
        off_d       = off_q;
        size_d      = size_q;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_bmask_d = '0;
        mem_wren_d  = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef LSU_MISALIGN_EN
        hi_addr_d   = hi_addr_q;
        wdata_d     = wdata_q;
        load_buf_d  = load_buf_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    state_d    = ACC0;
                    we_d       = i_req_we;
                    uns_d      = i_req_unsigned;
                    legal_d    = req_legal;
                    off_d      = i_req_addr[1:0];
                    size_d     = size_e'(i_req_size);
                    mem_addr_d = {i_req_addr[ADDR_W-1:2], 2'b00};
                    if (req_legal) begin
                        mem_bmask_d = size_mask(size_e'(i_req_size)) << i_req_addr[1:0];
                        mem_wdata_d = i_req_wdata << {i_req_addr[1:0], 3'b000};
                        mem_wren_d  = i_req_we;
                    end
`ifdef LSU_MISALIGN_EN
                    hi_addr_d = {i_req_addr[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
                    wdata_d   = i_req_wdata;
`endif
                end
            end
            ACC0: begin
                if (go_split) begin
`ifdef LSU_MISALIGN_EN
                    state_d     = ACC1;
                    mem_addr_d  = hi_addr_q;
                    mem_bmask_d = size_mask(size_q) >> (3'd4 - {1'b0, off_q});
                    mem_wdata_d = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
                    mem_wren_d  = we_q;
                    load_buf_d  = ld_lo;
`endif
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !legal_q;
                    rsp_rdata_d = (legal_q && !we_q) ? ext_data : '0;
                end
            end
`ifdef LSU_MISALIGN_EN
            ACC1: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = we_q ? '0 : ext_data;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            legal_q     <= 1'b0;
            off_q       <= '0;
            size_q      <= SZ_BYTE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_bmask_q <= '0;
            mem_wren_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef LSU_MISALIGN_EN
            hi_addr_q   <= '0;
            wdata_q     <= '0;
            load_buf_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            legal_q     <= legal_d;
            off_q       <= off_d;
            size_q      <= size_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_bmask_q <= mem_bmask_d;
            mem_wren_q  <= mem_wren_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef LSU_MISALIGN_EN
            hi_addr_q   <= hi_addr_d;
            wdata_q     <= wdata_d;
            load_buf_q  <= load_buf_d;
`endif
        end
    end

    // Ready is gated by reset so it drops immediately and returns on release.
    assign o_req_ready = (state_q == IDLE) && !i_reset;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_bmask = mem_bmask_q;
    assign o_mem_wren  = mem_wren_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl; expectations follow LSU_MISALIGN_EN when defined.
module tb_lsu_ctrl;

    logic        i_clk, i_reset;
    logic        i_req_valid, o_req_ready, i_req_we, i_req_unsigned;
    logic [31:0] i_req_addr, i_req_wdata;
    logic [1:0]  i_req_size;
    logic        o_rsp_valid, o_rsp_err, o_mem_wren;
    logic [31:0] o_rsp_rdata, o_mem_addr, o_mem_wdata, i_mem_rdata;
    logic [3:0]  o_mem_bmask;
    logic [31:0] mem_fc, mem_100;
    int          n_tests, n_fail;

    lsu_ctrl #(.ADDR_W(32)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_we       (i_req_we),
        .i_req_addr     (i_req_addr),
        .i_req_wdata    (i_req_wdata),
        .i_req_size     (i_req_size),
        .i_req_unsigned (i_req_unsigned),
        .o_rsp_valid    (o_rsp_valid),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_err      (o_rsp_err),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .o_mem_bmask    (o_mem_bmask),
        .o_mem_wren     (o_mem_wren),
        .i_mem_rdata    (i_mem_rdata)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always_comb begin
        i_mem_rdata = 32'h0;
        if (o_mem_addr == 32'h0000_00FC) i_mem_rdata = mem_fc;
        if (o_mem_addr == 32'h0000_0100) i_mem_rdata = mem_100;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge in IDLE; returns on the falling edge inside ACC0.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
        i_req_we       = we;
        i_req_addr     = addr;
        i_req_size     = size;
        i_req_unsigned = uns;
        i_req_wdata    = wdata;
        i_req_valid    = 1'b1;
        chk("ready_before_accept", o_req_ready, 1);
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        @(negedge i_clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        i_reset = 1'b1;
        i_req_valid = 1'b0; i_req_we = 1'b0; i_req_unsigned = 1'b0;
        i_req_addr = '0; i_req_wdata = '0; i_req_size = 2'b00;
        mem_fc  = 32'hAABB_CCDD;
        mem_100 = 32'h8A00_0000;

        // Reset state
        @(negedge i_clk);
        @(negedge i_clk);
        chk("rst_ready", o_req_ready, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_wren", o_mem_wren, 0);
        chk("rst_addr", o_mem_addr, 0);
        chk("rst_bmask", o_mem_bmask, 0);
        i_reset = 1'b0;
        #1 chk("ready_after_release", o_req_ready, 1);
        @(negedge i_clk);

        // SW 0x100
        issue(1'b1, 32'h100, 2'b10, 1'b0, 32'hDEAD_BEEF);
        chk("sw_addr", o_mem_addr, 32'h100);
        chk("sw_bmask", o_mem_bmask, 4'b1111);
        chk("sw_wdata", o_mem_wdata, 32'hDEAD_BEEF);
        chk("sw_wren", o_mem_wren, 1);
        chk("sw_acc0_no_rsp", o_rsp_valid, 0);
        chk("sw_busy_ready", o_req_ready, 0);
        @(negedge i_clk);
        chk("sw_rsp_valid", o_rsp_valid, 1);
        chk("sw_rsp_err", o_rsp_err, 0);
        chk("sw_rsp_rdata", o_rsp_rdata, 0);
        chk("sw_resp_wren", o_mem_wren, 0);
        @(negedge i_clk);
        chk("sw_rsp_pulse_end", o_rsp_valid, 0);

        // LB / LBU 0x103, SH 0x102
        issue(1'b0, 32'h103, 2'b00, 1'b0, 32'h0);
        chk("lb_addr", o_mem_addr, 32'h100);
        chk("lb_bmask", o_mem_bmask, 4'b1000);
        chk("lb_wren", o_mem_wren, 0);
        @(negedge i_clk);
        chk("lb_rsp_valid", o_rsp_valid, 1);
        chk("lb_rdata", o_rsp_rdata, 32'hFFFF_FF8A);
        @(negedge i_clk);
        issue(1'b0, 32'h103, 2'b00, 1'b1, 32'h0);
        @(negedge i_clk);
        chk("lbu_rdata", o_rsp_rdata, 32'h0000_008A);
        chk("lbu_err", o_rsp_err, 0);
        @(negedge i_clk);
        issue(1'b1, 32'h102, 2'b01, 1'b0, 32'h0000_1234);
        chk("sh_bmask", o_mem_bmask, 4'b1100);
        chk("sh_wdata", o_mem_wdata, 32'h1234_0000);
        chk("sh_wren", o_mem_wren, 1);
        @(negedge i_clk);
        chk("sh_rsp_valid", o_rsp_valid, 1);
        @(negedge i_clk);

        // Illegal size store
        issue(1'b1, 32'h100, 2'b11, 1'b0, 32'h1111_2222);
        chk("ill_wren", o_mem_wren, 0);
        chk("ill_bmask", o_mem_bmask, 0);
        @(negedge i_clk);
        chk("ill_rsp_valid", o_rsp_valid, 1);
        chk("ill_err", o_rsp_err, 1);
        chk("ill_rdata", o_rsp_rdata, 0);
        @(negedge i_clk);

        // LW 0x0FE crossing a word boundary
        mem_100 = 32'h1122_3344;
        issue(1'b0, 32'h0FE, 2'b10, 1'b0, 32'h0);
        chk("lw_mis_acc0_addr", o_mem_addr, 32'h0FC);
        chk("lw_mis_acc0_wren", o_mem_wren, 0);
`ifdef LSU_MISALIGN_EN
        chk("lw_mis_acc0_bmask", o_mem_bmask, 4'b1100);
        @(negedge i_clk);
        chk("lw_mis_acc1_addr", o_mem_addr, 32'h100);
        chk("lw_mis_acc1_bmask", o_mem_bmask, 4'b0011);
        chk("lw_mis_acc1_no_rsp", o_rsp_valid, 0);
        @(negedge i_clk);
        chk("lw_mis_rsp_valid", o_rsp_valid, 1);
        chk("lw_mis_rdata", o_rsp_rdata, 32'h3344_AABB);
        chk("lw_mis_err", o_rsp_err, 0);
`else
        chk("lw_mis_acc0_bmask", o_mem_bmask, 0);
        @(negedge i_clk);
        chk("lw_mis_rsp_valid", o_rsp_valid, 1);
        chk("lw_mis_err", o_rsp_err, 1);
        chk("lw_mis_rdata", o_rsp_rdata, 0);
`endif
        @(negedge i_clk);
        chk("lw_mis_idle", o_rsp_valid, 0);

        // SW 0x0FF crossing a word boundary
        issue(1'b1, 32'h0FF, 2'b10, 1'b0, 32'h1122_3344);
`ifdef LSU_MISALIGN_EN
        chk("sw_mis_acc0_bmask", o_mem_bmask, 4'b1000);
        chk("sw_mis_acc0_wdata", o_mem_wdata, 32'h4400_0000);
        chk("sw_mis_acc0_wren", o_mem_wren, 1);
        @(negedge i_clk);
        chk("sw_mis_acc1_addr", o_mem_addr, 32'h100);
        chk("sw_mis_acc1_bmask", o_mem_bmask, 4'b0111);
        chk("sw_mis_acc1_wdata", o_mem_wdata, 32'h0011_2233);
        chk("sw_mis_acc1_wren", o_mem_wren, 1);
        @(negedge i_clk);
        chk("sw_mis_err", o_rsp_err, 0);
`else
        chk("sw_mis_wren", o_mem_wren, 0);
        chk("sw_mis_bmask", o_mem_bmask, 0);
        @(negedge i_clk);
        chk("sw_mis_err", o_rsp_err, 1);
`endif
        chk("sw_mis_rsp_valid", o_rsp_valid, 1);
        @(negedge i_clk);

        // Reset during ACC0 of the split store
        issue(1'b1, 32'h0FF, 2'b10, 1'b0, 32'h1122_3344);
        i_reset = 1'b1;
        #1;
        chk("rstmid_wren", o_mem_wren, 0);
        chk("rstmid_bmask", o_mem_bmask, 0);
        chk("rstmid_addr", o_mem_addr, 0);
        chk("rstmid_wdata", o_mem_wdata, 0);
        chk("rstmid_ready", o_req_ready, 0);
        chk("rstmid_rsp_valid", o_rsp_valid, 0);
        @(posedge i_clk);
        #1 chk("rstmid_no_acc1_wren", o_mem_wren, 0);
        @(negedge i_clk);
        i_reset = 1'b0;
        #1 chk("rstmid_ready_release", o_req_ready, 1);
        @(negedge i_clk);
        chk("rstmid_post_wren", o_mem_wren, 0);
        chk("rstmid_post_rsp", o_rsp_valid, 0);

        // Valid held high across two back-to-back requests
        mem_100 = 32'h1122_F344;
        i_req_we = 1'b1; i_req_addr = 32'h100; i_req_size = 2'b10;
        i_req_unsigned = 1'b0; i_req_wdata = 32'h0BAD_F00D; i_req_valid = 1'b1;
        chk("b2b_ready_a", o_req_ready, 1);
        @(posedge i_clk);
        #1;
        i_req_we = 1'b0; i_req_size = 2'b01; i_req_wdata = 32'h0;
        @(negedge i_clk);
        chk("b2b_a_busy", o_req_ready, 0);
        chk("b2b_a_wdata", o_mem_wdata, 32'h0BAD_F00D);
        chk("b2b_a_wren", o_mem_wren, 1);
        @(negedge i_clk);
        chk("b2b_a_rsp", o_rsp_valid, 1);
        chk("b2b_a_rsp_busy", o_req_ready, 0);
        @(negedge i_clk);
        chk("b2b_ready_b", o_req_ready, 1);
        chk("b2b_a_single_pulse", o_rsp_valid, 0);
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        @(negedge i_clk);
        chk("b2b_b_wren", o_mem_wren, 0);
        chk("b2b_b_bmask", o_mem_bmask, 4'b0011);
        @(negedge i_clk);
        chk("b2b_b_rsp", o_rsp_valid, 1);
        chk("b2b_b_rdata", o_rsp_rdata, 32'hFFFF_F344);
        @(negedge i_clk);
        chk("b2b_b_done", o_rsp_valid, 0);
        @(negedge i_clk);
        chk("b2b_no_dup_rsp", o_rsp_valid, 0);
        chk("b2b_no_dup_wren", o_mem_wren, 0);
        chk("b2b_final_ready", o_req_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, address width of request and memory ports.
REQ-002 SHALL have port: i_clk  input  1  clock, rising edge.
REQ-003 SHALL have port: i_reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: i_req_valid  input  1  request valid; o_req_ready  output  1  request accepted when both high.
REQ-005 SHALL have ports: i_req_we  input  1  store=1/load=0; i_req_addr  input  ADDR_W  byte address; i_req_wdata  input  32  store data, LSB-justified.
REQ-006 SHALL have ports: i_req_size  input  2  00 byte, 01 half, 10 word, 11 illegal; i_req_unsigned  input  1  zero-extend loads.
REQ-007 SHALL have ports: o_rsp_valid  output  1  one-cycle completion pulse; o_rsp_rdata  output  32  extended load data; o_rsp_err  output  1  access error.
REQ-008 SHALL have memory ports: o_mem_addr  output  ADDR_W  word-aligned address; o_mem_wdata  output  32; o_mem_bmask  output  4; o_mem_wren  output  1; i_mem_rdata  input  32  asynchronous read data.

Function
REQ-009 SHALL implement FSM states IDLE, ACC0, ACC1, RESP; o_req_ready=1 only in IDLE.
REQ-010 SHALL latch the request on the accepting edge: IDLE->ACC0; ACC0->ACC1 if the access crosses a word boundary (addr[1:0]+bytes>4) and the access is legal, else ACC0->RESP; ACC1->RESP; RESP->IDLE.
REQ-011 SHALL assert o_rsp_valid exactly 2 cycles after acceptance for a single-word access and 3 cycles after acceptance for a split access, for exactly one cycle, for loads and stores alike.
REQ-012 In ACC0: o_mem_addr={addr[ADDR_W-1:2],2'b00}; bmask=(size mask<<off)[3:0]; wdata=wdata<<8*off; off=addr[1:0].
REQ-013 In ACC1: o_mem_addr=ACC0 address+4 (wraps modulo 2^ADDR_W); bmask=size mask>>(4-off); wdata=wdata>>8*(4-off).
REQ-014 o_mem_wren SHALL equal the latched we in ACC0/ACC1 only; in all other states wren=0, bmask=0, addr=0, wdata=0.
REQ-015 Loads: ACC0 SHALL capture i_mem_rdata>>8*off; ACC1 SHALL merge i_mem_rdata<<8*(4-off) into the upper bytes; RESP SHALL output the value sign- or zero-extended from size.
REQ-016 Stores SHALL return o_rsp_rdata=0.
REQ-017 size=11 SHALL be an error in all builds: no memory write, o_rsp_err=1, o_rsp_rdata=0.
REQ-018 o_rsp_err and o_rsp_rdata SHALL be registered and held stable; they are valid only while o_rsp_valid=1.

Reset
REQ-019 i_reset SHALL force IDLE asynchronously and abort any in-flight access; a split store interrupted in ACC0 SHALL NOT issue its ACC1 write.
REQ-020 While i_reset is high, all outputs including o_req_ready SHALL be 0; o_req_ready SHALL be 1 in the first cycle after deassertion.

Configuration
REQ-021 With LSU_MISALIGN_EN defined, misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0) SHALL be split per REQ-010..REQ-015.
REQ-022 Without LSU_MISALIGN_EN, such accesses SHALL go ACC0->RESP with wren=0 and bmask=0, and RESP SHALL give o_rsp_err=1, o_rsp_rdata=0; the ACC1 state and merge logic are not compiled.

Structure
REQ-023 Package lsu_pkg SHALL hold the size encoding enum, the FSM state enum, and functions for byte count and byte mask per size.
REQ-024 A combinational sub-module lsu_ext SHALL perform load sign/zero extension; all other logic SHALL reside in lsu_ctrl.

Verification
REQ-025 SW addr 0x100 wdata 0xDEADBEEF -> ACC0 mem addr 0x100, bmask 1111, wdata 0xDEADBEEF, wren=1; rsp_valid 2 cycles after acceptance, err=0.
REQ-026 mem[0x100]=0x8A000000: LB 0x103 -> rdata 0xFFFFFF8A; LBU 0x103 -> 0x0000008A; SH 0x102 wdata 0x1234 -> bmask 1100, wdata 0x12340000.
REQ-027 LSU_MISALIGN_EN defined, mem[0xFC]=0xAABBCCDD, mem[0x100]=0x11223344: LW 0x0FE -> ACC0 addr 0xFC, ACC1 addr 0x100, rdata 0x3344AABB, rsp_valid 3 cycles after acceptance.
REQ-028 LSU_MISALIGN_EN defined: SW 0x0FF wdata 0x11223344 -> ACC0 bmask 1000 wdata 0x44000000; ACC1 bmask 0111 wdata 0x00112233. Without the macro -> no wren, err=1.
REQ-029 Reset pulsed during ACC0 of the split store in REQ-028 -> no ACC1 write, all outputs 0; ready=1 in the first cycle after release.
REQ-030 i_req_valid held high over two requests -> ready=0 while busy; second request accepted in the cycle after the first rsp_valid; no request dropped or duplicated.
